// File: rtl/fetch_unit.sv
// fetch_unit: single-issue instruction fetch stage with IF/ID pipeline register.
// Ports:
//   clk             - clock, all state updates on posedge
//   reset           - synchronous active-high reset
//   stall           - hold fetch stage and IF/ID register
//   redirect_valid  - taken branch/jump from EX
//   redirect_target - new fetch byte address (bits [1:0] ignored)
//   imem_addr       - byte address to instruction memory
//   imem_data       - registered memory output for last cycle's imem_addr
//   id_pc           - PC of instruction in IF/ID
//   id_pc4          - id_pc + 4, for link writes
//   id_instr        - instruction in IF/ID (NOP_INSTR when bubble)
//   id_valid        - IF/ID holds a real instruction
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h00000000,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    output logic [31:0] id_instr,
    output logic        id_valid
);
    logic [31:0] pc;
    logic [31:0] resp_pc;
    logic        resp_valid;
    logic [31:0] target;

    assign target = {redirect_target[31:2], 2'b00};

    // On stall the outstanding address is reissued so imem_data still matches resp_pc afterwards.
    assign imem_addr = reset          ? RESET_PC :
                       redirect_valid ? target   :
                       stall          ? resp_pc  : pc;

    assign id_pc4 = id_pc + 32'd4;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc         <= RESET_PC;
            resp_pc    <= RESET_PC;
            resp_valid <= 1'b0;
            id_pc      <= 32'd0;
            id_instr   <= NOP_INSTR;
            id_valid   <= 1'b0;
        end else if (redirect_valid) begin
            // Flush: drop whatever is returning now and restart at the target.
            pc         <= target + 32'd4;
            resp_pc    <= target;
            resp_valid <= 1'b1;
            id_instr   <= NOP_INSTR;
            id_valid   <= 1'b0;
        end else if (!stall) begin
            pc         <= pc + 32'd4;
            resp_pc    <= pc;
            resp_valid <= 1'b1;
            id_pc      <= resp_pc;
            id_instr   <= resp_valid ? imem_data : NOP_INSTR;
            id_valid   <= resp_valid;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'd0;
    logic [31:0] imem_addr;
    logic [31:0] imem_data = 32'd0;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic [31:0] id_instr;
    logic        id_valid;
    int pass_cnt = 0;
    int total_cnt = 0;

    fetch_unit dut (
        .clk(clk), .reset(reset), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .id_pc(id_pc), .id_pc4(id_pc4), .id_instr(id_instr), .id_valid(id_valid)
    );

    always #5 clk = ~clk;

    // memory word n holds 0x1000_0000 + n, n = addr[7:2]
    always @(posedge clk) imem_data <= 32'h10000000 + {26'd0, imem_addr[7:2]};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else pass_cnt++;
    endtask

    task automatic chk_id(input string name, input logic [31:0] pc, input logic [31:0] instr);
        chk({name, " valid"}, {31'd0, id_valid}, 32'd1);
        chk({name, " pc"}, id_pc, pc);
        chk({name, " pc4"}, id_pc4, pc + 32'd4);
        chk({name, " instr"}, id_instr, instr);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        chk("rst id_valid", {31'd0, id_valid}, 32'd0);
        chk("rst id_instr", id_instr, 32'h00000013);
        chk("rst id_pc", id_pc, 32'd0);
        chk("rst imem_addr", imem_addr, 32'd0);
        reset = 1'b0;
        #1;
        chk("rel c1 imem_addr", imem_addr, 32'd0);
        chk("rel c1 id_valid", {31'd0, id_valid}, 32'd0);
        tick();
        chk("rel c2 id_valid", {31'd0, id_valid}, 32'd0);
        tick();
        chk_id("rel c3", 32'd0, 32'h10000000);
    endtask

    task automatic test_free_run();
        for (int k = 1; k <= 2; k++) begin
            tick();
            chk_id("run", 32'(4 * k), 32'h10000000 + 32'(k));
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall imem_addr", imem_addr, 32'd12);
            chk_id("stall hold", 32'd8, 32'h10000002);
            tick();
        end
        stall = 1'b0;
        #1;
        chk_id("stall last", 32'd8, 32'h10000002);
        tick();
        chk_id("stall rel1", 32'd12, 32'h10000003);
        tick();
        chk_id("stall rel2", 32'd16, 32'h10000004);
    endtask

    task automatic test_redirect();
        redirect_valid = 1'b1;
        redirect_target = 32'h40;
        #1;
        chk("redir imem_addr", imem_addr, 32'h40);
        tick();
        redirect_valid = 1'b0;
        chk("redir bubble valid", {31'd0, id_valid}, 32'd0);
        chk("redir bubble instr", id_instr, 32'h00000013);
        tick();
        chk_id("redir tgt", 32'h40, 32'h10000010);
        tick();
        chk_id("redir tgt+4", 32'h44, 32'h10000011);
    endtask

    task automatic test_redirect_stall();
        stall = 1'b1;
        redirect_valid = 1'b1;
        redirect_target = 32'h20;
        #1;
        chk("rs imem_addr", imem_addr, 32'h20);
        tick();
        stall = 1'b0;
        redirect_valid = 1'b0;
        chk("rs bubble valid", {31'd0, id_valid}, 32'd0);
        tick();
        chk_id("rs tgt", 32'h20, 32'h10000008);
    endtask

    task automatic test_misaligned();
        redirect_valid = 1'b1;
        redirect_target = 32'h43;
        #1;
        chk("mis imem_addr", imem_addr, 32'h40);
        tick();
        redirect_valid = 1'b0;
        tick();
        chk_id("mis tgt", 32'h40, 32'h10000010);
    endtask

    task automatic test_back_to_back();
        redirect_valid = 1'b1;
        redirect_target = 32'h80;
        tick();
        chk("b2b r1 valid", {31'd0, id_valid}, 32'd0);
        redirect_target = 32'h30;
        #1;
        chk("b2b imem_addr", imem_addr, 32'h30);
        tick();
        redirect_valid = 1'b0;
        chk("b2b r2 valid", {31'd0, id_valid}, 32'd0);
        tick();
        chk_id("b2b tgt", 32'h30, 32'h1000000C);
        tick();
        chk_id("b2b tgt+4", 32'h34, 32'h1000000D);
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1;
        redirect_target = 32'hFFFFFFFC;
        tick();
        redirect_valid = 1'b0;
        tick();
        chk_id("wrap top", 32'hFFFFFFFC, 32'h1000003F);
        chk("wrap pc4", id_pc4, 32'h00000000);
        tick();
        chk_id("wrap zero", 32'h00000000, 32'h10000000);
    endtask

    task automatic test_reset_mid_stall();
        stall = 1'b1;
        tick();
        chk_id("rms held", 32'h00000000, 32'h10000000);
        reset = 1'b1;
        redirect_valid = 1'b1;
        redirect_target = 32'h50;
        #1;
        chk("rms imem_addr", imem_addr, 32'd0);
        tick();
        chk("rms id_valid", {31'd0, id_valid}, 32'd0);
        chk("rms id_instr", id_instr, 32'h00000013);
        chk("rms imem_addr2", imem_addr, 32'd0);
        reset = 1'b0;
        stall = 1'b0;
        redirect_valid = 1'b0;
        tick();
        tick();
        chk_id("rms restart", 32'd0, 32'h10000000);
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_misaligned();
        test_back_to_back();
        test_wrap();
        test_reset_mid_stall();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
